// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the ALU, the decoder and the writeback stage.
//   - ALUOp encodings (OP_ADD .. OP_OR)
//   - wb_state_t : writeback FSM states
//   - two_write()  : op writes Lower then Upper on consecutive cycles
//   - sets_flags() : op updates the zero/negative status flags
//   - is_valid_op(): op produces at least one register write
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_SWAP = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wb_state_t;

    function automatic logic two_write(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_SWAP);
    endfunction

    function automatic logic sets_flags(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_valid_op(input logic [3:0] op);
        return sets_flags(op) || two_write(op) ||
               (op == OP_MOV) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/alu_writeback.sv
// Writeback stage downstream of the ALU.
// Captures one ALU result per accepted transfer and writes it into the
// register file through a single write port. div and swap write Lower first,
// then Upper on the following cycle. Holds the zero/negative status flags.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   in_valid  : ALU result valid
//   in_ready  : stage can accept this cycle
//   in_op     : ALUOp of the result
//   in_lower  : ALU Lower result
//   in_upper  : ALU Upper result
//   in_rd     : destination of Lower
//   in_rs     : destination of Upper for swap
//   wr_en     : register-file write strobe (registered)
//   wr_addr   : register-file write address (registered)
//   wr_data   : register-file write data (registered)
//   flag_z    : last arithmetic Lower was zero
//   flag_n    : last arithmetic Lower was negative
//   busy      : FSM not idle
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int REM_REG = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_lower,
    input  logic [DATA_W-1:0] in_upper,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] REM_ADDR = ADDR_W'(REM_REG);

    wb_state_t         state_q;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] upper_q;
    logic [ADDR_W-1:0] hi_addr_q;   // Upper destination, resolved at capture
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              flag_z_q;
    logic              flag_n_q;

    logic accept;

    // Ready depends only on registered state, so there is no combinational
    // path from in_valid back to in_ready.
    assign in_ready = (state_q == IDLE) ||
                      (state_q == WR_HI) ||
                      ((state_q == WR_LO) && !two_write(op_q));
    assign accept   = in_valid && in_ready;

    // NOTE: all state below is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            upper_q   <= '0;
            hi_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
        end else if (accept) begin
            op_q      <= in_op;
            upper_q   <= in_upper;
            hi_addr_q <= (in_op == OP_DIV) ? REM_ADDR : in_rs;
            if (is_valid_op(in_op)) begin
                state_q   <= WR_LO;
                wr_en_q   <= 1'b1;
                wr_addr_q <= in_rd;
                wr_data_q <= in_lower;
                if (sets_flags(in_op)) begin
                    flag_z_q <= (in_lower == '0);
                    flag_n_q <= in_lower[DATA_W-1];
                end
            end else begin
                // Unknown op: swallowed without a write or flag update.
                state_q <= IDLE;
                wr_en_q <= 1'b0;
            end
        end else if ((state_q == WR_LO) && two_write(op_q)) begin
            // Second write of div/swap. On an address collision this write
            // lands after the Lower write, so Upper wins.
            state_q   <= WR_HI;
            wr_en_q   <= 1'b1;
            wr_addr_q <= hi_addr_q;
            wr_data_q <= upper_q;
        end else begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign flag_z  = flag_z_q;
    assign flag_n  = flag_n_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback. Expected register writes are pushed
// to a scoreboard queue when the stimulus is driven and popped by a monitor
// on each falling edge where wr_en is high. Cycle-specific outputs are
// checked directly in the stimulus sequence.
module tb_alu_writeback;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_SWAP = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_lower;
    logic [15:0] in_upper;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        flag_z;
    logic        flag_n;
    logic        busy;

    int  n_vec;
    int  n_err;
    wr_t exp_q[$];

    alu_writeback #(
        .DATA_W (16),
        .ADDR_W (4),
        .REM_REG(15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op   (in_op),
        .in_lower(in_lower),
        .in_upper(in_upper),
        .in_rd   (in_rd),
        .in_rs   (in_rs),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] lo,
                         input logic [15:0] hi, input logic [3:0] rd, input logic [3:0] rs);
        in_valid = v;
        in_op    = op;
        in_lower = lo;
        in_upper = hi;
        in_rd    = rd;
        in_rs    = rs;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst && wr_en) begin
            check("sb_write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("sb_wr_addr", 32'(wr_addr), 32'(e.addr));
                check("sb_wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        idle();

        // Reset state
        tick();
        tick();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_flag_z", 32'(flag_z), 32'd0);
        check("rst_flag_n", 32'(flag_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        tick();
        check("release_no_write", 32'(wr_en), 32'd0);

        // 1: add rd=3 lower=5
        drive(1'b1, OP_ADD, 16'h0005, 16'h0000, 4'd3, 4'd0);
        check("add_ready", 32'(in_ready), 32'd1);
        push(4'd3, 16'h0005);
        tick();
        idle();
        check("add_wr_en", 32'(wr_en), 32'd1);
        check("add_addr", 32'(wr_addr), 32'd3);
        check("add_data", 32'(wr_data), 32'h0005);
        check("add_flag_z", 32'(flag_z), 32'd0);
        check("add_flag_n", 32'(flag_n), 32'd0);
        check("add_ready_wrlo", 32'(in_ready), 32'd1);
        tick();
        check("add_done_wr_en", 32'(wr_en), 32'd0);
        check("add_done_busy", 32'(busy), 32'd0);

        // 2: div rd=2 lower=3 upper=1
        drive(1'b1, OP_DIV, 16'h0003, 16'h0001, 4'd2, 4'd0);
        push(4'd2, 16'h0003);
        push(4'd15, 16'h0001);
        tick();
        idle();
        check("div_lo_ready", 32'(in_ready), 32'd0);
        check("div_lo_addr", 32'(wr_addr), 32'd2);
        check("div_lo_data", 32'(wr_data), 32'h0003);
        tick();
        check("div_hi_wr_en", 32'(wr_en), 32'd1);
        check("div_hi_addr", 32'(wr_addr), 32'd15);
        check("div_hi_data", 32'(wr_data), 32'h0001);
        check("div_hi_ready", 32'(in_ready), 32'd1);
        tick();
        check("div_done_wr_en", 32'(wr_en), 32'd0);

        // 3: swap rd=4 rs=5; Lower has MSB set but flags must not move
        drive(1'b1, OP_SWAP, 16'hAAAA, 16'h5555, 4'd4, 4'd5);
        push(4'd4, 16'hAAAA);
        push(4'd5, 16'h5555);
        tick();
        idle();
        check("swap_lo_addr", 32'(wr_addr), 32'd4);
        check("swap_lo_ready", 32'(in_ready), 32'd0);
        check("swap_flag_n", 32'(flag_n), 32'd0);
        tick();
        check("swap_hi_addr", 32'(wr_addr), 32'd5);
        check("swap_hi_data", 32'(wr_data), 32'h5555);
        check("swap_flag_z", 32'(flag_z), 32'd0);
        tick();

        // 4: back-to-back or/sub/and, in_valid held high
        drive(1'b1, OP_OR, 16'h00F0, 16'h0000, 4'd1, 4'd0);
        push(4'd1, 16'h00F0);
        tick();
        check("b2b_or_wr_en", 32'(wr_en), 32'd1);
        drive(1'b1, OP_SUB, 16'h0000, 16'h0000, 4'd6, 4'd0);
        check("b2b_ready_1", 32'(in_ready), 32'd1);
        push(4'd6, 16'h0000);
        tick();
        check("b2b_sub_wr_en", 32'(wr_en), 32'd1);
        check("b2b_sub_flag_z", 32'(flag_z), 32'd1);
        drive(1'b1, OP_AND, 16'h1234, 16'h0000, 4'd7, 4'd0);
        check("b2b_ready_2", 32'(in_ready), 32'd1);
        push(4'd7, 16'h1234);
        tick();
        idle();
        check("b2b_and_wr_en", 32'(wr_en), 32'd1);
        check("b2b_and_addr", 32'(wr_addr), 32'd7);
        check("b2b_and_keeps_z", 32'(flag_z), 32'd1);
        tick();
        check("b2b_done_wr_en", 32'(wr_en), 32'd0);

        // 5: unknown op, then an add
        drive(1'b1, OP_BAD, 16'h0001, 16'h0000, 4'd8, 4'd0);
        check("bad_ready", 32'(in_ready), 32'd1);
        tick();
        idle();
        check("bad_no_write", 32'(wr_en), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);
        check("bad_flag_z", 32'(flag_z), 32'd1);
        check("bad_flag_n", 32'(flag_n), 32'd0);
        drive(1'b1, OP_ADD, 16'h8001, 16'h0000, 4'd9, 4'd0);
        push(4'd9, 16'h8001);
        tick();
        idle();
        check("add2_addr", 32'(wr_addr), 32'd9);
        check("add2_flag_z", 32'(flag_z), 32'd0);
        check("add2_flag_n", 32'(flag_n), 32'd1);
        tick();

        // 6: reset during WR_LO of a div drops the R15 write
        drive(1'b1, OP_DIV, 16'h0007, 16'h0009, 4'd10, 4'd0);
        push(4'd10, 16'h0007);
        tick();
        idle();
        check("rdiv_lo_wr_en", 32'(wr_en), 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rdiv_wr_en_now", 32'(wr_en), 32'd0);
        check("rdiv_busy_now", 32'(busy), 32'd0);
        check("rdiv_flag_n_cleared", 32'(flag_n), 32'd0);
        tick();
        check("rdiv_no_r15", 32'(wr_en), 32'd0);
        rst = 1'b1;
        check("rdiv_ready", 32'(in_ready), 32'd1);
        check("rdiv_idle", 32'(busy), 32'd0);
        tick();
        check("rdiv_release_no_write", 32'(wr_en), 32'd0);
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
